apb2uart_host: RTL and testbench

APB completer that forwards each APB access as a command over a UART link and returns the far-end reply. It is the initiator end of the uart2apb command link: APB writes are serialized as 7-byte write frames, APB reads as 3-byte read frames followed by a 4-byte response on `rx`. It sits on the local APB bus; `tx`/`rx` connect to a remote uart2apb.

---
 rtl/apb2uart_host.sv | 224 ++++++++++++++++++++++
 tb/tb_apb2uart_host.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb2uart_host.sv
// apb2uart_host: APB completer that tunnels each access to a remote uart2apb over an
// 8-O-1 UART link (write = 7-byte command, read = 3-byte command plus 4-byte reply).
module apb2uart_host #(
   parameter int CLKS_PER_BIT   = 434,
   parameter int APB_ADDR_WIDTH = 16,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      psel,
   input  logic                      penable,
   input  logic                      pwrite,
   input  logic [APB_ADDR_WIDTH-1:0] paddr,
   input  logic [APB_DATA_WIDTH-1:0] pwdata,
   output logic                      pready,
   output logic [APB_DATA_WIDTH-1:0] prdata,
   output logic                      pslverr,
   output logic                      tx,
   input  logic                      rx,
   output logic                      busy
);
   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CLK_MID  = CW'(CLKS_PER_BIT / 2);
   localparam logic [31:0]   TMO_LIM  = 32'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, TX_BYTE, RX_WAIT, RX_BYTE, DONE} state_t;

   state_t        state_q, state_d;
   logic          write_q, write_d;
   logic [15:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [2:0]    byte_q, byte_d;
   logic [3:0]    bit_q, bit_d;
   logic [CW-1:0] clk_q, clk_d;
   logic [31:0]   tmo_q, tmo_d;
   logic [8:0]    rx_shift_q, rx_shift_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          tx_q, tx_d;
   logic [31:0]   prdata_q, prdata_d;
   logic          pslverr_q, pslverr_d;
   logic          rx_meta_q, rx_sync_q, rx_prev_q;
   logic          rx_fall;
   logic [2:0]    last_byte;

   function automatic logic [7:0] cmd_byte(input logic wr, input logic [2:0] idx,
                                           input logic [15:0] a, input logic [31:0] d);
      logic [7:0] b;
      case (idx)
         3'd0:    b = wr ? 8'hA5 : 8'h5A;
         3'd1:    b = a[7:0];
         3'd2:    b = a[15:8];
         3'd3:    b = d[7:0];
         3'd4:    b = d[15:8];
         3'd5:    b = d[23:16];
         default: b = d[31:24];
      endcase
      return b;
   endfunction

   // Bit n of an 11-bit frame: start, d0..d7, odd parity, stop.
   function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] n);
      logic v;
      if (n == 4'd0)       v = 1'b0;
      else if (n <= 4'd8)  v = b[3'(n - 4'd1)];
      else if (n == 4'd9)  v = ~^b;
      else                 v = 1'b1;
      return v;
   endfunction

   assign rx_fall   = rx_prev_q & ~rx_sync_q;
   assign last_byte = write_q ? 3'd6 : 3'd2;

   always_comb begin
      state_d    = state_q;
      write_d    = write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      byte_d     = byte_q;
      bit_d      = bit_q;
      clk_d      = clk_q;
      tmo_d      = tmo_q;
      rx_shift_d = rx_shift_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      tx_d       = 1'b1;
      prdata_d   = '0;
      pslverr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d = TX_BYTE;
               write_d = pwrite;
               addr_d  = paddr[15:0];
               wdata_d = pwdata[31:0];
               byte_d  = '0;
               bit_d   = '0;
               clk_d   = '0;
               tmo_d   = '0;
               err_d   = 1'b0;
               rdata_d = '0;
            end
         end
         TX_BYTE: begin
            clk_d = clk_q + 1'b1;
            if (clk_q == CLK_LAST) begin
               clk_d = '0;
               bit_d = bit_q + 4'd1;
               if (bit_q == 4'd10) begin
                  bit_d  = '0;
                  byte_d = byte_q + 3'd1;
                  if (byte_q == last_byte) begin
                     byte_d  = '0;
                     tmo_d   = '0;
                     state_d = write_q ? DONE : RX_WAIT;
                  end
               end
            end
         end
         RX_WAIT: begin
            tmo_d = tmo_q + 32'd1;
            if (tmo_d == TMO_LIM) begin
               state_d = DONE;
               err_d   = 1'b1;
            end else if (rx_fall) begin
               state_d = RX_BYTE;
               clk_d   = '0;
               bit_d   = '0;
            end
         end
         RX_BYTE: begin
            clk_d = clk_q + 1'b1;
            if (clk_q == CLK_LAST) begin
               clk_d = '0;
               bit_d = bit_q + 4'd1;
            end
            if (clk_q == CLK_MID) begin
               if (bit_q == 4'd0) begin
                  // Start bit high again: the edge was a glitch, timeout keeps running.
                  if (rx_sync_q) begin
                     state_d = RX_WAIT;
                     clk_d   = '0;
                  end
               end else if (bit_q <= 4'd9) begin
                  rx_shift_d = {rx_sync_q, rx_shift_q[8:1]};
               end else begin
                  rdata_d = rdata_q | ({24'd0, rx_shift_q[7:0]} << {byte_q[1:0], 3'b000});
                  if (!(^rx_shift_q) || !rx_sync_q) err_d = 1'b1;
                  clk_d = '0;
                  bit_d = '0;
                  if (byte_q == 3'd3) begin
                     state_d = DONE;
                  end else begin
                     byte_d  = byte_q + 3'd1;
                     tmo_d   = '0;
                     state_d = RX_WAIT;
                  end
               end
            end
         end
         DONE: begin
            if (psel && penable) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (state_d == TX_BYTE) tx_d = frame_bit(cmd_byte(write_d, byte_d, addr_d, wdata_d), bit_d);
      if (state_d == DONE) begin
         pslverr_d = err_d;
         prdata_d  = (write_d || err_d) ? 32'd0 : rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         write_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         byte_q     <= '0;
         bit_q      <= '0;
         clk_q      <= '0;
         tmo_q      <= '0;
         rx_shift_q <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         tx_q       <= 1'b1;
         prdata_q   <= '0;
         pslverr_q  <= 1'b0;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         write_q    <= write_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         byte_q     <= byte_d;
         bit_q      <= bit_d;
         clk_q      <= clk_d;
         tmo_q      <= tmo_d;
         rx_shift_q <= rx_shift_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         tx_q       <= tx_d;
         prdata_q   <= prdata_d;
         pslverr_q  <= pslverr_d;
         rx_meta_q  <= rx;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
      end
   end

   // APB handshake: an access completes in the cycle where psel, penable and pready are all
   // high; pready is only raised in DONE and only while the master is in its access phase.
   assign pready  = (state_q == DONE) && psel && penable;
   assign prdata  = prdata_q;
   assign pslverr = pslverr_q;
   assign tx      = tx_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_apb2uart_host.sv
// tb_apb2uart_host: directed and randomized APB accesses against a frame-level model of the
// UART command link, with an independent tx decoder and an rx reply driver.
module tb_apb2uart_host;
   localparam int CPB = 16;
   localparam int TMO = 600;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [15:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic        rx = 1'b1;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;
   logic        tx;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int          r_lat;
   int          r_tready;
   logic [31:0] r_rd;
   logic        r_err;
   int          rx_start_cyc;
   logic [9:0]  tx_got[$];

   apb2uart_host #(
      .CLKS_PER_BIT  (CPB),
      .APB_ADDR_WIDTH(16),
      .APB_DATA_WIDTH(32),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .psel   (psel),
      .penable(penable),
      .pwrite (pwrite),
      .paddr  (paddr),
      .pwdata (pwdata),
      .pready (pready),
      .prdata (prdata),
      .pslverr(pslverr),
      .tx     (tx),
      .rx     (rx),
      .busy   (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   // tx decoder: samples mid-bit, stores {stop, parity, data} per frame.
   initial begin
      logic [9:0] fr;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int b = 0; b < 10; b++) begin
               repeat (CPB) @(negedge clk);
               fr[b] = tx;
            end
            tx_got.push_back(fr);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic flip);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ flip, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         rx = f[i];
         if (i == 0) rx_start_cyc = cyc;
         repeat (CPB - 1) @(negedge clk);
      end
   endtask

   task automatic apb_xfer(input logic wr, input logic [15:0] a, input logic [31:0] d);
      int t0;
      r_lat = -1;
      r_rd  = 'x;
      r_err = 1'bx;
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      t0 = cyc;
      @(negedge clk);
      penable = 1'b1;
      check("start_bit", tx, 0);
      check("busy_rise", busy, 1);
      for (int n = 0; n < 4000 && r_lat < 0; n++) begin
         if (pready === 1'b1) begin
            r_lat    = cyc - t0;
            r_tready = cyc;
            r_rd     = prdata;
            r_err    = pslverr;
         end else begin
            @(negedge clk);
         end
      end
      @(negedge clk);
      check("pready_single", pready, 0);
      check("prdata_clear", prdata, 0);
      check("busy_fall", busy, 0);
      psel = 1'b0; penable = 1'b0;
   endtask

   // mode: 0 clean reply, 1 no reply, 2 glitch before reply, 3 write with rx noise.
   task automatic do_xfer(input string tag, input logic wr, input logic [15:0] a,
                          input logic [31:0] d, input logic [31:0] reply,
                          input int bad_idx, input int mode);
      logic [7:0]  exp_tx[$];
      logic [31:0] exp_rd;
      logic        exp_err;
      int          b3;
      exp_tx.push_back(wr ? 8'hA5 : 8'h5A);
      exp_tx.push_back(a[7:0]);
      exp_tx.push_back(a[15:8]);
      if (wr) begin
         exp_tx.push_back(d[7:0]);
         exp_tx.push_back(d[15:8]);
         exp_tx.push_back(d[23:16]);
         exp_tx.push_back(d[31:24]);
      end
      exp_err = !wr && (mode == 1 || bad_idx < 4);
      exp_rd  = (wr || exp_err) ? 32'd0 : reply;
      b3 = 0;
      tx_got.delete();
      fork
         apb_xfer(wr, a, d);
         begin
            if (!wr && mode != 1) begin
               repeat (33 * CPB + 1) @(negedge clk);
               if (mode == 2) begin
                  repeat (40) @(negedge clk);
                  rx = 1'b0;
                  repeat (CPB / 4) @(negedge clk);
                  rx = 1'b1;
               end
               for (int k = 0; k < 4; k++) begin
                  repeat (100) @(negedge clk);
                  send_byte(reply[8*k +: 8], k == bad_idx);
               end
               b3 = rx_start_cyc;
            end else if (wr && mode == 3) begin
               repeat (2 * CPB) @(negedge clk);
               send_byte(8'hC3, 1'b0);
            end
         end
      join
      check({tag, "_seen"}, r_lat > 0, 1);
      if (wr) check({tag, "_lat"}, r_lat, 1 + 77 * CPB);
      else if (mode == 1) check({tag, "_lat"}, r_lat, 1 + 33 * CPB + TMO);
      else check({tag, "_lat_win"},
                 (r_tready - b3 >= 10 * CPB + CPB / 2 + 1) && (r_tready - b3 <= 11 * CPB), 1);
      check({tag, "_prdata"}, r_rd, exp_rd);
      check({tag, "_pslverr"}, r_err, exp_err);
      check({tag, "_tx_count"}, tx_got.size(), exp_tx.size());
      foreach (exp_tx[i]) begin
         if (i < tx_got.size())
            check({tag, "_tx_frame"}, tx_got[i], {1'b1, ~^exp_tx[i], exp_tx[i]});
      end
   endtask

   initial begin
      logic        wr;
      logic [15:0] a;
      logic [31:0] d;
      logic [31:0] rep;
      int          bi;
      logic        saw_busy;

      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_pready", pready, 0);
      check("rst_prdata", prdata, 0);
      check("rst_pslverr", pslverr, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);

      do_xfer("wr_clean", 1'b1, 16'h6564, 32'h0D0C0B0A, 32'd0, 4, 0);
      do_xfer("rd_clean", 1'b0, 16'h3332, 32'd0, 32'h0E0D0C0B, 4, 0);
      do_xfer("rd_tmo", 1'b0, 16'h1234, 32'd0, 32'd0, 4, 1);
      do_xfer("rd_par", 1'b0, 16'hBEEF, 32'd0, 32'h44332211, 2, 0);
      do_xfer("rd_glitch", 1'b0, 16'h0F0F, 32'd0, 32'hCAFEF00D, 4, 2);
      do_xfer("wr_rxnoise", 1'b1, 16'hA0A0, 32'h12345678, 32'd0, 4, 3);

      saw_busy = 1'b0;
      fork
         send_byte(8'h96, 1'b0);
         begin
            repeat (11 * CPB + 6) begin
               @(negedge clk);
               if (busy !== 1'b0) saw_busy = 1'b1;
            end
         end
      join
      check("idle_rx_busy", saw_busy, 0);

      // Abort a write during command byte 3 (data byte 0x00, so tx is low there).
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h5555; pwdata = 32'hFFFFFF00;
      @(negedge clk);
      penable = 1'b1;
      repeat (38 * CPB) @(negedge clk);
      check("pre_rst_tx", tx, 0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_tx", tx, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_pready", pready, 0);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      saw_busy = 1'b0;
      repeat (12 * CPB) begin
         @(negedge clk);
         if (busy !== 1'b0 || pready !== 1'b0) saw_busy = 1'b1;
      end
      check("post_rst_quiet", saw_busy, 0);
      do_xfer("wr_after_rst", 1'b1, 16'h7E81, 32'hA5A55A5A, 32'd0, 4, 0);

      for (int i = 0; i < 6; i++) begin
         wr  = 1'($urandom_range(0, 1));
         a   = 16'($urandom);
         d   = $urandom;
         rep = $urandom;
         bi  = $urandom_range(0, 7);
         do_xfer("rand", wr, a, d, rep, bi, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
